reg_file: RTL and testbench



---
 rtl/reg_file.sv | 36 +++
 tb/tb_reg_file.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// 8 x 8 register file: two combinational read ports, one clocked write port.
// Every register clears asynchronously on RESET; R0 is an ordinary register.
module reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] INADDRESS,
    input  logic [DATA_WIDTH-1:0] IN,
    input  logic [ADDR_WIDTH-1:0] OUT1ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2ADDRESS,
    output logic [DATA_WIDTH-1:0] OUT1,
    output logic [DATA_WIDTH-1:0] OUT2
);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Reset outranks a write landing on the same edge.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (WRITE) begin
            regs[INADDRESS] <= IN;
        end
    end

    // No write bypass: a read of the target shows the old value until the edge.
    assign OUT1 = regs[OUT1ADDRESS];
    assign OUT2 = regs[OUT2ADDRESS];

endmodule

// File: tb/tb_reg_file.sv
// Directed bench for reg_file: array model updated per transaction plus
// a per-cycle compare process and hand-computed literal checks.
`timescale 1ns/1ps
module tb_reg_file;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       WRITE;
    logic [2:0] INADDRESS;
    logic [7:0] IN;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;

    int errors = 0;
    int checks = 0;
    logic [7:0] m [8];

    reg_file dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .WRITE       (WRITE),
        .INADDRESS   (INADDRESS),
        .IN          (IN),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clr_model();
        for (int i = 0; i < 8; i++) m[i] = 8'h00;
    endtask

    // Called just after a rising edge; returns just after the write edge.
    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WRITE = 1'b1;
        INADDRESS = a;
        IN = d;
        @(posedge CLK);
        #1;
        m[a] = d;
        WRITE = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a1, input logic [2:0] a2);
        OUT1ADDRESS = a1;
        OUT2ADDRESS = a2;
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Per-cycle comparison of both read ports against the model.
    always @(negedge CLK) begin
        check("port1", OUT1, m[OUT1ADDRESS]);
        check("port2", OUT2, m[OUT2ADDRESS]);
        if (WRITE && $isunknown(INADDRESS)) begin
            checks++;
            errors++;
            $display("FAIL waddr_x: got %b expected a known address", INADDRESS);
        end
    end

    initial begin
        logic [7:0] sum;
        clr_model();
        RESET = 1'b1;
        WRITE = 1'b0;
        INADDRESS = 3'd0;
        IN = 8'h00;
        OUT1ADDRESS = 3'd0;
        OUT2ADDRESS = 3'd0;
        idle(2);
        check("reset_out1", OUT1, 8'h00);
        RESET = 1'b0;
        idle(1);

        // Asynchronous reset mid-cycle after loading R3.
        wr(3'd3, 8'h5A);
        rd(3'd3, 3'd3);
        check("r3_loaded", OUT1, 8'h5A);
        #1;
        RESET = 1'b1;
        clr_model();
        #1;
        check("reset_async", OUT1, 8'h00);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 3'(7 - a));
            check("reset_sweep1", OUT1, 8'h00);
            check("reset_sweep2", OUT2, 8'h00);
        end
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle(1);

        // Basic write and read on both ports.
        wr(3'd2, 8'h3C);
        rd(3'd2, 3'd2);
        check("basic_out1", OUT1, 8'h3C);
        check("basic_out2", OUT2, 8'h3C);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a), 3'(a));
            check("basic_sweep", OUT1, (a == 2) ? 8'h3C : 8'h00);
        end

        // Write disabled for three edges.
        wr(3'd5, 8'h11);
        WRITE = 1'b0;
        INADDRESS = 3'd5;
        IN = 8'hFF;
        idle(3);
        rd(3'd5, 3'd5);
        check("wdis_r5", OUT1, 8'h11);

        // Read during write: old value until the edge, no bypass.
        wr(3'd1, 8'h07);
        rd(3'd1, 3'd1);
        WRITE = 1'b1;
        INADDRESS = 3'd1;
        IN = 8'h80;
        #1;
        check("rdw_before", OUT1, 8'h07);
        @(posedge CLK);
        #1;
        m[1] = 8'h80;
        WRITE = 1'b0;
        check("rdw_after", OUT1, 8'h80);

        // Back-to-back writes and the ALU ADD operand path.
        wr(3'd0, 8'h01);
        wr(3'd7, 8'hFE);
        wr(3'd0, 8'h02);
        rd(3'd0, 3'd7);
        check("b2b_r0", OUT1, 8'h02);
        check("b2b_r7", OUT2, 8'hFE);
        sum = OUT1 + OUT2;
        check("alu_add", sum, 8'h00);

        // Reset rising on the same edge as a write to R4.
        WRITE = 1'b1;
        INADDRESS = 3'd4;
        IN = 8'hAA;
        @(posedge CLK);
        RESET = 1'b1;
        clr_model();
        #1;
        WRITE = 1'b0;
        rd(3'd4, 3'd4);
        check("coinc_r4", OUT1, 8'h00);
        WRITE = 1'b1;
        IN = 8'hCC;
        idle(2);
        check("reset_blocks_wr", OUT1, 8'h00);
        WRITE = 1'b0;
        RESET = 1'b0;
        idle(2);
        check("coinc_hold", OUT1, 8'h00);
        wr(3'd4, 8'h5B);
        check("post_reset_wr", OUT1, 8'h5B);
        idle(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
